// File: rtl/alufpu_if.sv
// Operand and result buses between the register file, the execute stage and writeback.
// There is no handshake: results are valid one clock after the operands are presented.
interface alufpu_if;
  logic [31:0] busA;
  logic [31:0] busB;
  logic [3:0]  ALUctrl;
  logic [31:0] fbusA;
  logic [31:0] fbusB;
  logic        FPUctrl;
  logic [31:0] ALUout;
  logic [31:0] FPUout;
  logic        branch;

  modport master (
    output busA, busB, ALUctrl, fbusA, fbusB, FPUctrl,
    input  ALUout, FPUout, branch
  );

  modport slave (
    input  busA, busB, ALUctrl, fbusA, fbusB, FPUctrl,
    output ALUout, FPUout, branch
  );
endinterface

// File: rtl/alufpu.sv
// Execute stage: 16-function integer ALU with a zero/branch flag, plus a 32-bit multiplier.
// Latency 1 cycle: every edge loads new results; there is no stall or backpressure path.
module alufpu (
  input  logic     clk,
  input  logic     reset,
  alufpu_if.slave  bus
);

  logic [31:0] alu_d, alu_q;
  logic [31:0] fpu_d, fpu_q;
  logic        branch_d, branch_q;

  logic [4:0]  shamt;
  logic        mul_signed;
  logic [63:0] mul_opa, mul_opb, mul_prod;
  logic [31:0] mul_hi_unused;

  assign shamt = bus.busB[4:0];

  always_comb begin
    alu_d = 32'd0;
    case (bus.ALUctrl)
      4'd0:  alu_d = bus.busA + bus.busB;
      4'd1:  alu_d = bus.busA - bus.busB;
      4'd2:  alu_d = bus.busA & bus.busB;
      4'd3:  alu_d = bus.busA | bus.busB;
      4'd4:  alu_d = bus.busA ^ bus.busB;
      4'd5:  alu_d = bus.busA << shamt;
      4'd6:  alu_d = bus.busA >> shamt;
      4'd7:  alu_d = $signed(bus.busA) >>> shamt;
      4'd8:  alu_d = {31'd0, bus.busA == bus.busB};
      4'd9:  alu_d = {31'd0, bus.busA != bus.busB};
      4'd10: alu_d = {31'd0, $signed(bus.busA) <  $signed(bus.busB)};
      4'd11: alu_d = {31'd0, $signed(bus.busA) >  $signed(bus.busB)};
      4'd12: alu_d = {31'd0, $signed(bus.busA) <= $signed(bus.busB)};
      4'd13: alu_d = {31'd0, $signed(bus.busA) >= $signed(bus.busB)};
      4'd14: alu_d = {bus.busB[15:0], 16'h0000};
      default: alu_d = bus.busA;
    endcase
  end

  // Branch flag is taken from the very value being loaded into ALUout.
  assign branch_d = (alu_d == 32'd0);

  // Full 64-bit product with MULT/MULTU sign extension; only the low word is exported today.
  assign mul_signed = ~bus.FPUctrl;
  assign mul_opa    = {{32{mul_signed & bus.fbusA[31]}}, bus.fbusA};
  assign mul_opb    = {{32{mul_signed & bus.fbusB[31]}}, bus.fbusB};
  assign mul_prod   = mul_opa * mul_opb;
  assign {mul_hi_unused, fpu_d} = mul_prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q    <= 32'd0;
      fpu_q    <= 32'd0;
      branch_q <= 1'b0;
    end else begin
      alu_q    <= alu_d;
      fpu_q    <= fpu_d;
      branch_q <= branch_d;
    end
  end

  assign bus.ALUout = alu_q;
  assign bus.FPUout = fpu_q;
  assign bus.branch = branch_q;

endmodule

// File: tb/tb_alufpu.sv
// Scoreboard bench for alufpu: directed vectors followed by random traffic against a reference model.
module tb_alufpu;

  logic clk;
  logic reset;
  alufpu_if bus ();

  alufpu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] fpu;
    logic        br;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] c, input logic [31:0] fa,
                                 input logic [31:0] fb, input logic fc, input string name);
    exp_t        e;
    int          sa, sb, sh;
    longint      sprod;
    longint unsigned uprod;
    logic [63:0] p;
    sa = int'(a);
    sb = int'(b);
    sh = int'(b % 32);
    case (c)
      4'd0:  e.alu = a + b;
      4'd1:  e.alu = a - b;
      4'd2:  e.alu = a & b;
      4'd3:  e.alu = a | b;
      4'd4:  e.alu = a ^ b;
      4'd5:  e.alu = a << sh;
      4'd6:  e.alu = a >> sh;
      4'd7:  e.alu = 32'(sa >>> sh);
      4'd8:  e.alu = (a == b) ? 32'd1 : 32'd0;
      4'd9:  e.alu = (a != b) ? 32'd1 : 32'd0;
      4'd10: e.alu = (sa <  sb) ? 32'd1 : 32'd0;
      4'd11: e.alu = (sa >  sb) ? 32'd1 : 32'd0;
      4'd12: e.alu = (sa <= sb) ? 32'd1 : 32'd0;
      4'd13: e.alu = (sa >= sb) ? 32'd1 : 32'd0;
      4'd14: e.alu = (b % 65536) * 65536;
      default: e.alu = a;
    endcase
    if (fc) begin
      uprod = longint'({32'd0, fa}) * longint'({32'd0, fb});
      p = uprod;
    end else begin
      sprod = longint'(int'(fa)) * longint'(int'(fb));
      p = sprod;
    end
    e.fpu  = p[31:0];
    e.br   = (e.alu == 32'd0);
    e.name = name;
    return e;
  endfunction

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                       input logic [31:0] fa, input logic [31:0] fb, input logic fc,
                       input string name);
    @(negedge clk);
    bus.busA    = a;
    bus.busB    = b;
    bus.ALUctrl = c;
    bus.fbusA   = fa;
    bus.fbusB   = fb;
    bus.FPUctrl = fc;
    exp_q.push_back(model(a, b, c, fa, fb, fc, name));
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bus.ALUout !== 32'd0 || bus.FPUout !== 32'd0 || bus.branch !== 1'b0) begin
      errors++;
      $display("FAIL %s: got alu=%h fpu=%h br=%b, want all zero", name,
               bus.ALUout, bus.FPUout, bus.branch);
    end
  endtask

  // Monitor: results appear one edge after the operands, sampled 2 ns later.
  always @(posedge clk) begin
    #2;
    if (!reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.ALUout !== e.alu || bus.FPUout !== e.fpu || bus.branch !== e.br) begin
        errors++;
        $display("FAIL %s: got alu=%h fpu=%h br=%b, want alu=%h fpu=%h br=%b", e.name,
                 bus.ALUout, bus.FPUout, bus.branch, e.alu, e.fpu, e.br);
      end
    end
  end

  initial begin
    logic [31:0] a, b, fa, fb;
    logic [3:0]  c;
    reset       = 1'b0;
    bus.busA    = '0;
    bus.busB    = '0;
    bus.ALUctrl = '0;
    bus.fbusA   = '0;
    bus.fbusB   = '0;
    bus.FPUctrl = 1'b0;

    // Load non-zero results, then reset between edges and expect an immediate clear.
    apply(32'd2, 32'd4, 4'd0, 32'd3, 32'd5, 1'b0, "pre_reset_add");
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;

    // In-flight result discarded when reset lands before the loading edge.
    @(negedge clk);
    bus.busA = 32'd9; bus.busB = 32'd9; bus.ALUctrl = 4'd0;
    bus.fbusA = 32'd7; bus.fbusB = 32'd7;
    #2 reset = 1'b1;
    @(posedge clk);
    #1 check_zero("inflight_discard");
    @(negedge clk);
    reset = 1'b0;

    apply(32'd2,          32'd4,  4'd0,  32'd0, 32'd0, 1'b0, "add_after_reset");
    apply(32'hFFFFFFFF,   32'd4,  4'd1,  32'd0, 32'd0, 1'b0, "sub_neg");
    apply(32'hFFFFFFFF,   32'd4,  4'd2,  32'd0, 32'd0, 1'b0, "and");
    apply(32'd28,         32'd4,  4'd3,  32'd0, 32'd0, 1'b0, "or");
    apply(32'd36,         32'd4,  4'd4,  32'd0, 32'd0, 1'b0, "xor");
    apply(32'd4,          32'd4,  4'd1,  32'd0, 32'd0, 1'b0, "sub_zero_branch");
    apply(32'd32,         32'd0,  4'd5,  32'd0, 32'd0, 1'b0, "sll_zero");
    apply(32'd32,         32'd36, 4'd6,  32'd0, 32'd0, 1'b0, "srl_shamt_mask");
    apply(32'h80000000,   32'd4,  4'd7,  32'd0, 32'd0, 1'b0, "sra");
    apply(32'h80000000,   32'd4,  4'd6,  32'd0, 32'd0, 1'b0, "srl");
    apply(32'd4,          32'd36, 4'd10, 32'd0, 32'd0, 1'b0, "slt_lt");
    apply(32'd40,         32'd36, 4'd10, 32'd0, 32'd0, 1'b0, "slt_gt");
    apply(32'd36,         32'd36, 4'd10, 32'd0, 32'd0, 1'b0, "slt_eq");
    apply(32'd40,         32'd40, 4'd13, 32'd0, 32'd0, 1'b0, "sge_eq");
    apply(32'd41,         32'd40, 4'd13, 32'd0, 32'd0, 1'b0, "sge_gt");
    apply(32'd40,         32'd32, 4'd12, 32'd0, 32'd0, 1'b0, "sle_false_branch");
    apply(32'hFFFFFFFF,   32'd1,  4'd10, 32'd0, 32'd0, 1'b0, "slt_signed");
    apply(32'd1,          32'd1,  4'd15, 32'hFFFFFFFC, 32'd8, 1'b0, "mult_neg");
    apply(32'd1,          32'd1,  4'd15, 32'hFFFFFFFC, 32'hFFFFFFF8, 1'b0, "mult_negneg");
    apply(32'd1,          32'd1,  4'd15, 32'hFFFFFFFC, 32'd8, 1'b1, "multu");
    apply(32'd0,          32'h1234ABCD, 4'd14, 32'd3, 32'd3, 1'b0, "lhi");
    apply(32'd7,          32'd0,  4'd15, 32'd6, 32'd7, 1'b1, "passa_concurrent");
    apply(32'd5,          32'd5,  4'd8,  32'h10000, 32'h10000, 1'b0, "seq_mult_wrap");
    apply(32'd5,          32'd5,  4'd9,  32'd0, 32'd0, 1'b0, "sne_eq");
    apply(32'h7FFFFFFF,   32'h80000000, 4'd11, 32'd0, 32'd0, 1'b0, "sgt_signed");

    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = $urandom;
      fa = $urandom;
      fb = $urandom;
      c  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = 32'($urandom_range(0, 64)); b = 32'($urandom_range(0, 64)); end
        default: ;
      endcase
      apply(a, b, c, fa, fb, 1'($urandom_range(0, 1)), "random");
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
